// File: rtl/rom_burst_reader_if.sv
// Burst request / beat response bus between a requester and rom_burst_reader.
interface rom_burst_reader_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LEN_WIDTH-1:0]  req_len;
   logic                  req_fixed;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_last;
   logic                  rsp_miss;

   modport master (
      output req_valid, req_addr, req_len, req_fixed, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_miss
   );

   modport slave (
      input  req_valid, req_addr, req_len, req_fixed, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_last, rsp_miss
   );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst reader over a tiny constant ROM. A request captures start address,
// length and fixed/increment mode; beats are then streamed one per accepted
// handshake, with each beat's ROM word registered one cycle ahead.
module rom_burst_reader #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 8,
   parameter int LEN_WIDTH    = 4,
   parameter int DEFAULT_DATA = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   rom_burst_reader_if.slave   bus,
   output logic                busy
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base_addr, beat_addr;
   logic [LEN_WIDTH-1:0]  len_q, idx, idx_nxt;
   logic                  fixed_q;
   logic                  accept, load_beat, last_nxt;
   logic [DATA_WIDTH-1:0] data_q, rom_data;
   logic                  last_q, miss_q, rom_miss;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, and which beat (if any) gets loaded into the output register
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load_beat = 1'b0;
      idx_nxt   = idx;
      beat_addr = base_addr;
      last_nxt  = last_q;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept    = 1'b1;
               state_nxt = STREAM;
               load_beat = 1'b1;
               idx_nxt   = '0;
               beat_addr = bus.req_addr;
               last_nxt  = (bus.req_len == '0);
            end
         end
         STREAM: begin
            if (bus.rsp_ready) begin
               if (last_q) begin
                  state_nxt = IDLE;
               end else begin
                  // Prefetch the following beat so transfers run back-to-back
                  load_beat = 1'b1;
                  idx_nxt   = idx + LEN_WIDTH'(1);
                  beat_addr = fixed_q ? base_addr : base_addr + ADDR_WIDTH'(idx_nxt);
                  last_nxt  = (idx_nxt == len_q);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ROM contents: 0..4 map to themselves, 6 maps to 5, everything else misses
   always_comb begin
      rom_data = DATA_WIDTH'(DEFAULT_DATA);
      rom_miss = 1'b1;
      if (beat_addr <= ADDR_WIDTH'(4)) begin
         rom_data = DATA_WIDTH'(beat_addr);
         rom_miss = 1'b0;
      end else if (beat_addr == ADDR_WIDTH'(6)) begin
         rom_data = DATA_WIDTH'(5);
         rom_miss = 1'b0;
      end
   end

   // Request capture and registered beat outputs (held while stalled)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_addr <= '0;
         len_q     <= '0;
         fixed_q   <= 1'b0;
         idx       <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         if (accept) begin
            base_addr <= bus.req_addr;
            len_q     <= bus.req_len;
            fixed_q   <= bus.req_fixed;
         end
         if (load_beat) begin
            idx    <= idx_nxt;
            data_q <= rom_data;
            last_q <= last_nxt;
            miss_q <= rom_miss;
         end
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == STREAM);
   assign busy          = (state == STREAM);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_last  = last_q;
   assign bus.rsp_miss  = miss_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed and randomized bursts against a beat-list reference model.
module tb_rom_burst_reader;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   vectors = 0;
   int   miscompares = 0;

   rom_burst_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .LEN_WIDTH(4)) bus ();

   rom_burst_reader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ROM: 0..4 -> addr, 6 -> 5, else 255 with miss
   function automatic void rom_ref(input logic [11:0] a, output logic [7:0] d, output logic m);
      if (a <= 12'd4)      begin d = a[7:0]; m = 1'b0; end
      else if (a == 12'd6) begin d = 8'd5;   m = 1'b0; end
      else                 begin d = 8'd255; m = 1'b1; end
   endfunction

   // Called at posedge+1 with DUT idle. One request, then beat-by-beat checks.
   task automatic do_burst(input logic [11:0] a, input logic [3:0] l, input bit f,
                           input int stall_beat, input int stall_n, input bit rnd,
                           input bit hold, input int abort_at);
      logic [7:0]  ed [16];
      logic        em [16];
      logic [11:0] ai;
      int          n;
      n = int'(l) + 1;
      for (int i = 0; i < n; i++) begin
         ai = f ? a : a + 12'(i);
         rom_ref(ai, ed[i], em[i]);
      end
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_len   = l;
      bus.req_fixed = f;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("idle_busy",      32'(busy),          32'd0);
      @(posedge clk); #1;
      if (!hold) bus.req_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         int waits;
         int cyc;
         bit took;
         waits = (k == stall_beat) ? stall_n : 0;
         cyc   = 0;
         if (k == abort_at) begin
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            chk("abort_beat_data", 32'(bus.rsp_data), 32'(ed[k]));
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
            chk("abort_busy",      32'(busy),          32'd0);
            chk("abort_rsp_last",  32'(bus.rsp_last),  32'd0);
            @(posedge clk); #1;
            return;
         end
         do begin
            bus.rsp_ready = (cyc >= waits) &&
                            (!rnd || cyc >= waits + 6 || $urandom_range(0, 3) != 0);
            if (hold) bus.req_addr = 12'($urandom);
            took = bus.rsp_ready;
            @(negedge clk);
            chk($sformatf("beat%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("beat%0d_data", k),  32'(bus.rsp_data),  32'(ed[k]));
            chk($sformatf("beat%0d_last", k),  32'(bus.rsp_last),  32'(k == n - 1));
            chk($sformatf("beat%0d_miss", k),  32'(bus.rsp_miss),  32'(em[k]));
            chk($sformatf("beat%0d_busy", k),  32'(busy),          32'd1);
            chk($sformatf("beat%0d_rdy", k),   32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
         end while (!took);
      end
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.req_fixed = 1'b0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      chk("rst_rsp_last",  32'(bus.rsp_last),  32'd0);
      chk("rst_rsp_miss",  32'(bus.rsp_miss),  32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Incrementing burst 0..3
      do_burst(12'h000, 4'd3, 1'b0, -1, 0, 1'b0, 1'b0, -1);
      // Crosses the unmapped hole at 5
      do_burst(12'h004, 4'd2, 1'b0, -1, 0, 1'b0, 1'b0, -1);
      // Address wrap from max to 0
      do_burst(12'hFFF, 4'd1, 1'b0, -1, 0, 1'b0, 1'b0, -1);
      // Fixed mode with a 3-cycle stall on beat 1
      do_burst(12'h002, 4'd2, 1'b1, 1, 3, 1'b0, 1'b0, -1);
      // Reset during beat 3 of an 8-beat burst, then a clean single beat
      do_burst(12'h000, 4'd7, 1'b0, -1, 0, 1'b0, 1'b0, 3);
      do_burst(12'h001, 4'd0, 1'b0, -1, 0, 1'b0, 1'b0, -1);
      // req_valid held high: the follow-up is taken only in the idle cycle
      do_burst(12'h003, 4'd3, 1'b0, -1, 0, 1'b0, 1'b1, -1);
      do_burst(12'h006, 4'd1, 1'b0, -1, 0, 1'b0, 1'b0, -1);
      // Full-length burst ending on the maximum beat count
      do_burst(12'hFF8, 4'd15, 1'b0, -1, 0, 1'b0, 1'b0, -1);

      // Randomized bursts with random back-pressure
      for (int t = 0; t < 25; t++) begin
         logic [11:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 9));
         do_burst(ra, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  -1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("final_idle_ready", 32'(bus.req_ready), 32'd1);
      chk("final_idle_valid", 32'(bus.rsp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, data width in bits.
REQ-003 Parameter LEN_WIDTH, default 4, burst-length field width; a burst is req_len+1 beats.
REQ-004 Parameter DEFAULT_DATA, default 255, value returned for unmapped addresses.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 req_valid  input  1  burst request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_addr  input  ADDR_WIDTH  burst start address.
REQ-010 req_len  input  LEN_WIDTH  beats minus one.
REQ-011 req_fixed  input  1  1 = every beat reads req_addr; 0 = address increments per beat.
REQ-012 rsp_valid  output  1  rsp_data/rsp_last/rsp_miss are valid.
REQ-013 rsp_ready  input  1  consumer accepts current beat.
REQ-014 rsp_data  output  DATA_WIDTH  ROM word for current beat.
REQ-015 rsp_last  output  1  current beat is the final beat of the burst.
REQ-016 rsp_miss  output  1  current beat's address is unmapped (rsp_data = DEFAULT_DATA).
REQ-017 busy  output  1  a burst is in progress (state STREAM).

Function
REQ-018 ROM contents SHALL be: addr 0..4 -> value equal to addr; addr 6 -> 5; all other addresses -> DEFAULT_DATA with rsp_miss=1; values zero-extended/truncated to DATA_WIDTH.
REQ-019 FSM SHALL have two states: IDLE and STREAM.
REQ-020 IDLE: req_ready=1, rsp_valid=0, busy=0; request accepted on req_valid&&req_ready.
REQ-021 On accept, block SHALL capture addr, len, fixed, go to STREAM, and present beat 0 registered in the next cycle (one-cycle latency).
REQ-022 STREAM: req_ready=0, rsp_valid=1, busy=1; req_valid ignored.
REQ-023 Beat transfers on rsp_valid&&rsp_ready; without rsp_ready, rsp_data/rsp_last/rsp_miss SHALL hold stable.
REQ-024 After a non-last transfer, next beat SHALL appear the following cycle with no bubble (back-to-back beats at full rate).
REQ-025 Beat address: fixed mode = start addr for all beats; increment mode = start + beat index, modulo 2^ADDR_WIDTH (wraps max -> 0).
REQ-026 rsp_last=1 exactly on beat index req_len; req_len=0 gives a single beat with rsp_last=1.
REQ-027 On last-beat transfer, FSM SHALL return to IDLE; rsp_valid=0 and req_ready=1 in the next cycle (one idle cycle between bursts).
REQ-028 Internal beat counter SHALL be LEN_WIDTH bits; max burst is 2^LEN_WIDTH beats.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_miss=0, busy=0.
REQ-030 Reset mid-burst SHALL abort the burst without further beats; the next request after reset starts cleanly.

Verification
REQ-031 Reset, then req addr=0x000, len=3, fixed=0, rsp_ready=1 -> beats 0,1,2,3 on consecutive cycles starting 1 cycle after accept, rsp_last only on 3, rsp_miss=0.
REQ-032 req addr=0x004, len=2, fixed=0 -> beats 4 (miss=0), 255 (miss=1), 5 (miss=0, last=1).
REQ-033 req addr=0xFFF, len=1, fixed=0 -> beats 255 (miss=1), 0 (miss=0, last=1): wrap-around.
REQ-034 req addr=0x002, len=2, fixed=1, rsp_ready low 3 cycles on beat 1 -> beats 2,2,2; beat 1 held stable during stall; last on beat 2.
REQ-035 Burst len=7, assert rst_n=0 during beat 3 -> next cycle rsp_valid=0, req_ready=1, busy=0; new req addr=0x001 len=0 -> single beat 1 with last=1.
REQ-036 req_valid held high through a burst -> second request accepted only in IDLE cycle after last transfer; no overlap of beats.
